// File: rtl/sys_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// sys_bus_arbiter_if
// Bundles the CPU/DMA request sets, the owner handshake and the shared slave
// bus that surround sys_bus_arbiter.
//   master modport : the arbiter's view (drives grants, acks, bus address/data/strobes)
//   slave  modport : the environment's view (bus masters and addressed slave)
// Signals:
//   cpu_*/dma_*      request, direction, burst code, address and write data per master
//   cpu_gnt/dma_gnt  bus ownership, beat_ack/rdata per completed beat
//   xfer_done/err    end-of-transaction pulses
//   Addr_bus, Data_bus_o, Data_bus_i, bus_wr, bus_rd, bus_burst, beat_idx, sel, slv_ready
// -----------------------------------------------------------------------------
interface sys_bus_arbiter_if #(
    parameter int unsigned DW = 32
);
    logic          cpu_req;
    logic          cpu_write;
    logic [1:0]    cpu_burst;
    logic [DW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;

    logic          dma_req;
    logic          dma_write;
    logic [1:0]    dma_burst;
    logic [DW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;

    logic          cpu_gnt;
    logic          dma_gnt;
    logic          beat_ack;
    logic [DW-1:0] rdata;
    logic          xfer_done;
    logic          xfer_err;

    logic [DW-1:0] Addr_bus;
    logic [DW-1:0] Data_bus_o;
    logic [DW-1:0] Data_bus_i;
    logic          bus_wr;
    logic          bus_rd;
    logic [1:0]    bus_burst;
    logic [1:0]    beat_idx;
    logic [2:0]    sel;
    logic          slv_ready;

    modport master (
        input  cpu_req, cpu_write, cpu_burst, cpu_addr, cpu_wdata,
        input  dma_req, dma_write, dma_burst, dma_addr, dma_wdata,
        input  Data_bus_i, slv_ready,
        output cpu_gnt, dma_gnt, beat_ack, rdata, xfer_done, xfer_err,
        output Addr_bus, Data_bus_o, bus_wr, bus_rd, bus_burst, beat_idx, sel
    );

    modport slave (
        output cpu_req, cpu_write, cpu_burst, cpu_addr, cpu_wdata,
        output dma_req, dma_write, dma_burst, dma_addr, dma_wdata,
        output Data_bus_i, slv_ready,
        input  cpu_gnt, dma_gnt, beat_ack, rdata, xfer_done, xfer_err,
        input  Addr_bus, Data_bus_o, bus_wr, bus_rd, bus_burst, beat_idx, sel
    );
endinterface

// File: rtl/sys_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sys_bus_arbiter
// Shared system-bus master stage for two masters (CPU, DMA) and three slaves
// (IO_1, IO_2, memory). One master owns the bus per transaction; the FSM walks
// IDLE -> ADDR -> DATA -> DONE and drives address, strobes, beat index and
// one-hot slave select, muxes write data out and returns read data.
// Ports:
//   clck     system clock, rising edge
//   Reset_n  asynchronous active-low reset
//   bus      sys_bus_arbiter_if.master (requests, grants, acks, slave bus)
// -----------------------------------------------------------------------------
module sys_bus_arbiter #(
    parameter int unsigned IO1_ADDR = 500,
    parameter int unsigned IO2_ADDR = 700,
    parameter int unsigned MEM_ADDR = 800,
    parameter int unsigned DW       = 32
) (
    input  logic               clck,
    input  logic               Reset_n,
    sys_bus_arbiter_if.master  bus
);
    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e        state_q, state_d;
    logic          owner_q;       // 1 = DMA owns the current transaction
    logic          last_owner_q;  // 1 = DMA owned the previous one
    logic          write_q;
    logic          err_q;
    logic [1:0]    burst_q;
    logic [1:0]    beat_q;
    logic [DW-1:0] addr_q;
    logic          beat_ack_q;
    logic [DW-1:0] rdata_q;

    logic          any_req;
    logic          pick_dma;
    logic [2:0]    sel_dec;
    logic          addr_err;
    logic [1:0]    last_beat;
    logic          beat_done;
    logic          final_beat;

    assign any_req = bus.cpu_req | bus.dma_req;

    // Round robin on a tie: the master that did not own the bus last time wins.
    always_comb begin
        pick_dma = bus.dma_req;
        if (bus.cpu_req && bus.dma_req) begin
            pick_dma = ~last_owner_q;
        end
    end

    always_comb begin
        sel_dec = 3'b000;
        if (addr_q == DW'(IO1_ADDR)) sel_dec = 3'b001;
        if (addr_q == DW'(IO2_ADDR)) sel_dec = 3'b010;
        if (addr_q == DW'(MEM_ADDR)) sel_dec = 3'b100;
    end

    assign addr_err = (sel_dec == 3'b000) || (burst_q == 2'd3);

    always_comb begin
        case (burst_q)
            2'd0:    last_beat = 2'd0;
            2'd1:    last_beat = 2'd1;
            default: last_beat = 2'd3;
        endcase
    end

    assign beat_done  = (state_q == StData) && bus.slv_ready;
    assign final_beat = beat_done && (beat_q == last_beat);

    // State register
    always_ff @(posedge clck or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (any_req) state_d = StAddr;
            StAddr: state_d = addr_err ? StDone : StData;
            StData: if (final_beat) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Transaction context, beat counter and read-data capture
    always_ff @(posedge clck or negedge Reset_n) begin
        if (!Reset_n) begin
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            burst_q      <= 2'd0;
            beat_q       <= 2'd0;
            addr_q       <= '0;
            beat_ack_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            beat_ack_q <= beat_done;
            if (state_q == StIdle && any_req) begin
                owner_q <= pick_dma;
                write_q <= pick_dma ? bus.dma_write : bus.cpu_write;
                burst_q <= pick_dma ? bus.dma_burst : bus.cpu_burst;
                addr_q  <= pick_dma ? bus.dma_addr  : bus.cpu_addr;
            end
            if (state_q == StAddr) begin
                err_q  <= addr_err;
                beat_q <= 2'd0;
            end
            if (beat_done) begin
                beat_q <= final_beat ? 2'd0 : beat_q + 2'd1;
                if (!write_q) rdata_q <= bus.Data_bus_i;
            end
            if (state_q == StDone) begin
                last_owner_q <= owner_q;
            end
        end
    end

    // Outputs
    always_comb begin
        bus.cpu_gnt    = 1'b0;
        bus.dma_gnt    = 1'b0;
        bus.xfer_done  = 1'b0;
        bus.xfer_err   = 1'b0;
        bus.Addr_bus   = '0;
        bus.Data_bus_o = '0;
        bus.bus_wr     = 1'b0;
        bus.bus_rd     = 1'b0;
        bus.bus_burst  = 2'd0;
        bus.beat_idx   = 2'd0;
        bus.sel        = 3'b000;
        unique case (state_q)
            StAddr, StData: begin
                bus.cpu_gnt   = ~owner_q;
                bus.dma_gnt   = owner_q;
                bus.Addr_bus  = addr_q;
                bus.sel       = sel_dec;
                bus.bus_burst = burst_q;
                if (state_q == StData) begin
                    bus.bus_wr   = write_q;
                    bus.bus_rd   = ~write_q;
                    bus.beat_idx = beat_q;
                    if (write_q) bus.Data_bus_o = owner_q ? bus.dma_wdata : bus.cpu_wdata;
                end
            end
            StDone: begin
                bus.xfer_done = 1'b1;
                bus.xfer_err  = err_q;
            end
            default: ;
        endcase
    end

    assign bus.beat_ack = beat_ack_q;
    assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Self-checking bench for sys_bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of ownership,
// timing and beat sequence.
module tb_sys_bus_arbiter;
    localparam int unsigned DW = 32;

    logic clck = 1'b0;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;
    bit   last_owner;  // model: 0 = CPU, 1 = DMA

    sys_bus_arbiter_if #(.DW(DW)) bus ();

    sys_bus_arbiter #(
        .IO1_ADDR (500),
        .IO2_ADDR (700),
        .MEM_ADDR (800),
        .DW       (DW)
    ) dut (
        .clck    (clck),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 clck = ~clck;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] sel_of(input logic [31:0] a);
        if (a == 500) return 3'b001;
        if (a == 700) return 3'b010;
        if (a == 800) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [127:0] all_outs();
        return {bus.cpu_gnt, bus.dma_gnt, bus.beat_ack, bus.rdata, bus.xfer_done, bus.xfer_err,
                bus.Addr_bus, bus.Data_bus_o, bus.bus_wr, bus.bus_rd, bus.bus_burst,
                bus.beat_idx, bus.sel};
    endfunction

    // One transaction from request to the idle cycle after DONE.
    task automatic xfer(input bit c_on, input bit c_wr, input logic [1:0] c_b,
                        input logic [31:0] c_a,
                        input bit d_on, input bit d_wr, input logic [1:0] d_b,
                        input logic [31:0] d_a,
                        input int wait_pct, input int stall);
        bit          o, wr, err, rdy, prev_rdy;
        logic [1:0]  b;
        logic [31:0] a, wd, rd, last_rd;
        logic [2:0]  s;
        int          beats, k, waits, sd, acks;

        o     = (c_on && d_on) ? !last_owner : d_on;
        wr    = o ? d_wr : c_wr;
        b     = o ? d_b : c_b;
        a     = o ? d_a : c_a;
        s     = sel_of(a);
        err   = (s == 3'b000) || (b == 2'd3);
        beats = 1 << b;

        @(negedge clck);
        bus.cpu_req = c_on; bus.cpu_write = c_wr; bus.cpu_burst = c_b; bus.cpu_addr = c_a;
        bus.dma_req = d_on; bus.dma_write = d_wr; bus.dma_burst = d_b; bus.dma_addr = d_a;
        bus.cpu_wdata = $urandom; bus.dma_wdata = $urandom;
        #1 chk("idle_gnt", {bus.cpu_gnt, bus.dma_gnt}, 2'b00);

        @(negedge clck);
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;  // drop is ignored mid-transaction
        #1;
        chk("addr_gnt", {bus.cpu_gnt, bus.dma_gnt}, {!o, o});
        chk("addr_bus", bus.Addr_bus, a);
        chk("addr_sel", bus.sel, s);
        chk("addr_strobes", {bus.bus_wr, bus.bus_rd}, 2'b00);
        chk("addr_burst", bus.bus_burst, b);

        if (err) begin
            @(negedge clck); #1;
            chk("err_done", {bus.xfer_done, bus.xfer_err}, 2'b11);
            chk("err_strobes", {bus.bus_wr, bus.bus_rd}, 2'b00);
            chk("err_gnt", {bus.cpu_gnt, bus.dma_gnt, bus.sel}, 5'b0);
        end else begin
            k = 0; waits = 0; sd = 0; acks = 0; prev_rdy = 1'b0; last_rd = '0;
            while (k < beats) begin
                @(negedge clck);
                if (k == 1 && sd < stall) begin
                    rdy = 1'b0; sd++;
                end else begin
                    rdy = (waits >= 3) || ($urandom_range(99) >= wait_pct);
                end
                wd = $urandom; rd = $urandom;
                if (o) bus.dma_wdata = wd; else bus.cpu_wdata = wd;
                bus.Data_bus_i = rd; bus.slv_ready = rdy;
                #1;
                chk("data_ack", bus.beat_ack, prev_rdy);
                acks += int'(bus.beat_ack);
                if (bus.beat_ack && !wr) chk("data_rdata", bus.rdata, last_rd);
                chk("data_strobes", {bus.bus_wr, bus.bus_rd}, {wr, !wr});
                chk("data_gnt", {bus.cpu_gnt, bus.dma_gnt}, {!o, o});
                chk("data_addr", bus.Addr_bus, a);
                chk("data_sel", bus.sel, s);
                chk("data_beat_idx", bus.beat_idx, k);
                chk("data_wdata", bus.Data_bus_o, wr ? wd : 32'd0);
                prev_rdy = rdy;
                if (rdy) begin
                    last_rd = rd; k++; waits = 0;
                end else begin
                    waits++;
                end
            end
            @(negedge clck);
            bus.slv_ready = 1'b0;
            #1;
            chk("done_flags", {bus.xfer_done, bus.xfer_err}, 2'b10);
            chk("done_ack", bus.beat_ack, 1'b1);
            acks += int'(bus.beat_ack);
            if (!wr) chk("done_rdata", bus.rdata, last_rd);
            chk("done_quiet", {bus.cpu_gnt, bus.dma_gnt, bus.bus_wr, bus.bus_rd, bus.sel,
                               bus.beat_idx}, 9'b0);
            chk("ack_count", acks, beats);
        end
        last_owner = o;
        @(negedge clck); #1;
        chk("post_idle", {bus.xfer_done, bus.beat_ack, bus.cpu_gnt, bus.dma_gnt}, 4'b0);
    endtask

    initial begin
        logic [31:0] addrs [5];
        bit          c_on, d_on;
        int          pick;

        Reset_n = 1'b0;
        bus.cpu_req = 0; bus.cpu_write = 0; bus.cpu_burst = 0; bus.cpu_addr = 0;
        bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_write = 0; bus.dma_burst = 0; bus.dma_addr = 0;
        bus.dma_wdata = 0;
        bus.Data_bus_i = 0; bus.slv_ready = 0;
        last_owner = 1'b0;
        repeat (2) @(negedge clck);
        #1 chk("reset_outputs", all_outs(), 128'd0);
        @(negedge clck);
        Reset_n = 1'b1;

        // Ties after reset: DMA first, then CPU.
        xfer(1, 1, 2'd0, 500, 1, 0, 2'd1, 800, 0, 0);
        xfer(1, 0, 2'd1, 700, 1, 1, 2'd0, 500, 0, 0);
        // Single CPU write to IO_1, DMA 4-beat read from memory.
        xfer(1, 1, 2'd0, 500, 0, 0, 2'd0, 0, 0, 0);
        xfer(0, 0, 2'd0, 0, 1, 0, 2'd2, 800, 0, 0);
        // CPU 2-beat read with a 3-cycle mid-burst stall.
        xfer(1, 0, 2'd1, 700, 0, 0, 2'd0, 0, 0, 3);
        // Unmapped address and illegal burst code.
        xfer(1, 1, 2'd0, 600, 0, 0, 2'd0, 0, 0, 0);
        xfer(1, 1, 2'd3, 500, 0, 0, 2'd0, 0, 0, 0);

        // Reset during DMA beat 2 of 4.
        @(negedge clck);
        bus.dma_req = 1; bus.dma_write = 0; bus.dma_burst = 2'd2; bus.dma_addr = 800;
        bus.slv_ready = 1; bus.Data_bus_i = 32'h1234_5678;
        @(negedge clck);
        bus.dma_req = 0;
        repeat (2) @(negedge clck);
        @(negedge clck);
        #1 chk("rst_pre_beat_idx", bus.beat_idx, 2'd2);
        #1 Reset_n = 1'b0;
        #1 chk("rst_abort_outputs", all_outs(), 128'd0);
        @(negedge clck);
        Reset_n = 1'b1; bus.slv_ready = 0;
        last_owner = 1'b0;
        repeat (2) begin
            @(negedge clck);
            #1 chk("rst_no_done", {bus.xfer_done, bus.beat_ack}, 2'b00);
        end
        // Tie after the abort goes to DMA again.
        xfer(1, 1, 2'd1, 800, 1, 1, 2'd1, 700, 0, 0);

        addrs[0] = 500; addrs[1] = 700; addrs[2] = 800; addrs[3] = 600; addrs[4] = $urandom;
        for (int n = 0; n < 25; n++) begin
            pick = $urandom_range(2);
            c_on = (pick != 1);
            d_on = (pick != 0);
            xfer(c_on, 1'($urandom), 2'($urandom_range(3)), addrs[$urandom_range(4)],
                 d_on, 1'($urandom), 2'($urandom_range(3)), addrs[$urandom_range(4)],
                 40, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
